// File: rtl/afifo_pkg.sv
// Shared async-FIFO pointer helpers: Gray/binary conversion, depth and CDC-depth legality.
package afifo_pkg;

    localparam int unsigned PTR_MAX         = 16;
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // Widest pointer vector; narrower pointers are zero-extended into it.
    typedef logic [PTR_MAX-1:0] ptr_t;

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic int unsigned depth_of(input int unsigned ptr_width);
        return 32'd1 << (ptr_width - 32'd1);
    endfunction

    function automatic bit sync_stages_ok(input int unsigned n);
        return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/rptr_sync_w_if.sv
// Write-side read-pointer bundle: pointers in, synchronized pointer and level status out.
interface rptr_sync_w_if #(
    parameter int unsigned PTR_WIDTH = 3
);
    logic [PTR_WIDTH-1:0] g_rptr;
    logic [PTR_WIDTH-1:0] b_wptr;
    logic [PTR_WIDTH-1:0] g_rptr_sync;
    logic [PTR_WIDTH-1:0] b_rptr_sync;
    logic [PTR_WIDTH-1:0] wr_used;
    logic [PTR_WIDTH-1:0] wr_free;
    logic                 almost_full;
    logic                 sync_valid;
    logic                 gray_err;

    modport master (
        output g_rptr, b_wptr,
        input  g_rptr_sync, b_rptr_sync, wr_used, wr_free, almost_full, sync_valid, gray_err
    );

    modport slave (
        input  g_rptr, b_wptr,
        output g_rptr_sync, b_rptr_sync, wr_used, wr_free, almost_full, sync_valid, gray_err
    );
endinterface

// File: rtl/ptr_sync.sv
// N-stage flop chain for bringing a Gray pointer across clock domains; pure flops, no logic.
module ptr_sync #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rptr_sync_w.sv
// Write-domain read-pointer receiver: CDC of the Gray read pointer, binary conversion, fill level.
// Optional GRAY_CHECK_EN adds a sticky gray_err for illegal Gray steps and level overruns.
module rptr_sync_w
    import afifo_pkg::*;
#(
    parameter int unsigned PTR_WIDTH    = 3,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned AF_THRESHOLD = 1
) (
    input logic          wclk,
    input logic          write_reset,
    rptr_sync_w_if.slave bus
);

    localparam logic [PTR_WIDTH-1:0] DEPTH_P  = PTR_WIDTH'(depth_of(PTR_WIDTH));
    localparam int unsigned          CNT_W    = $clog2(SYNC_STAGES + 3);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SYNC_STAGES + 1);

    generate
        if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_cfg
            $fatal(1, "rptr_sync_w: SYNC_STAGES out of range");
        end
    endgenerate

    logic [PTR_WIDTH-1:0] g_sync;
    logic [PTR_WIDTH-1:0] b_rptr;
    logic [PTR_WIDTH-1:0] wr_used;
    logic [PTR_WIDTH-1:0] wr_free;
    logic                 almost_full;
    logic                 sync_valid;
    logic [CNT_W-1:0]     cnt;
    logic [PTR_WIDTH-1:0] diff_c;
    logic [PTR_WIDTH-1:0] free_c;

`ifdef GRAY_CHECK_EN
    // Chain split so the penultimate stage is visible to the Gray step check.
    logic [PTR_WIDTH-1:0] g_prev;
    logic [PTR_WIDTH-1:0] step_c;
    logic                 multi_c;
    logic                 overrun_c;
    logic                 gray_err;

    ptr_sync #(.WIDTH(PTR_WIDTH), .STAGES(SYNC_STAGES - 1)) u_sync_head (
        .clk   (wclk),
        .rst_n (write_reset),
        .d     (bus.g_rptr),
        .q     (g_prev)
    );

    ptr_sync #(.WIDTH(PTR_WIDTH), .STAGES(1)) u_sync_tail (
        .clk   (wclk),
        .rst_n (write_reset),
        .d     (g_prev),
        .q     (g_sync)
    );

    always_comb begin
        step_c    = g_prev ^ g_sync;
        multi_c   = (step_c & (step_c - PTR_WIDTH'(1))) != '0;
        overrun_c = diff_c > DEPTH_P;
    end

    always_ff @(posedge wclk or negedge write_reset) begin
        if (!write_reset) begin
            gray_err <= 1'b0;
        end else if (sync_valid && (multi_c || overrun_c)) begin
            gray_err <= 1'b1;
        end
    end

    assign bus.gray_err = gray_err;
`else
    ptr_sync #(.WIDTH(PTR_WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (wclk),
        .rst_n (write_reset),
        .d     (bus.g_rptr),
        .q     (g_sync)
    );

    assign bus.gray_err = 1'b0;
`endif

    // Stale read pointer only inflates the difference, so free space is never over-reported.
    always_comb begin
        diff_c = bus.b_wptr - b_rptr;
        free_c = (diff_c > DEPTH_P) ? '0 : DEPTH_P - diff_c;
    end

    always_ff @(posedge wclk or negedge write_reset) begin
        if (!write_reset) begin
            b_rptr      <= '0;
            wr_used     <= '0;
            wr_free     <= DEPTH_P;
            almost_full <= 1'b0;
        end else begin
            b_rptr      <= PTR_WIDTH'(gray2bin(ptr_t'(g_sync)));
            wr_used     <= diff_c;
            wr_free     <= free_c;
            almost_full <= 32'(free_c) <= AF_THRESHOLD;
        end
    end

    // Valid once the CDC chain and both conversion stages hold post-reset data.
    always_ff @(posedge wclk or negedge write_reset) begin
        if (!write_reset) begin
            cnt        <= '0;
            sync_valid <= 1'b0;
        end else begin
            if (cnt != CNT_LAST) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (cnt == CNT_LAST) begin
                sync_valid <= 1'b1;
            end
        end
    end

    assign bus.g_rptr_sync = g_sync;
    assign bus.b_rptr_sync = b_rptr;
    assign bus.wr_used     = wr_used;
    assign bus.wr_free     = wr_free;
    assign bus.almost_full = almost_full;
    assign bus.sync_valid  = sync_valid;

endmodule

// File: tb/tb_rptr_sync_w.sv
// Directed bench for rptr_sync_w (PTR_WIDTH=3, SYNC_STAGES=2, AF_THRESHOLD=1); honours GRAY_CHECK_EN.
module tb_rptr_sync_w;

`ifdef GRAY_CHECK_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif

    logic wclk = 1'b0;
    logic write_reset;
    int   checks = 0;
    int   passes = 0;

    rptr_sync_w_if #(.PTR_WIDTH(3)) bus ();

    rptr_sync_w #(
        .PTR_WIDTH    (3),
        .SYNC_STAGES  (2),
        .AF_THRESHOLD (1)
    ) dut (
        .wclk        (wclk),
        .write_reset (write_reset),
        .bus         (bus.slave)
    );

    always #5 wclk = ~wclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge wclk);
        #1;
    endtask

    task automatic set_rptr(input logic [2:0] g);
        bus.g_rptr = g;
        tick(4);
    endtask

    task automatic chk_level(input string tag, input logic [2:0] used, input logic [2:0] free,
                             input logic af);
        chk({tag, "_used"}, 32'(bus.wr_used), 32'(used));
        chk({tag, "_free"}, 32'(bus.wr_free), 32'(free));
        chk({tag, "_af"},   32'(bus.almost_full), 32'(af));
    endtask

    initial begin
        // Reset sequence
        write_reset = 1'b0;
        bus.g_rptr  = 3'b000;
        bus.b_wptr  = 3'b000;
        #13;
        chk("rst_gsync", 32'(bus.g_rptr_sync), 32'd0);
        chk("rst_brptr", 32'(bus.b_rptr_sync), 32'd0);
        chk_level("rst", 3'd0, 3'd4, 1'b0);
        chk("rst_valid", 32'(bus.sync_valid), 32'd0);
        chk("rst_err",   32'(bus.gray_err), 32'd0);
        @(negedge wclk);
        write_reset = 1'b1;
        tick(3);
        chk("rel_valid3", 32'(bus.sync_valid), 32'd0);
        tick(1);
        chk("rel_valid4", 32'(bus.sync_valid), 32'd1);
        chk_level("rel", 3'd0, 3'd4, 1'b0);

        // Steady update: read pointer 1, write pointer 3
        bus.g_rptr = 3'b001;
        bus.b_wptr = 3'b011;
        tick(1);
        chk("st_gsync1", 32'(bus.g_rptr_sync), 32'b000);
        chk_level("st_wptr1", 3'd3, 3'd1, 1'b1);
        tick(1);
        chk("st_gsync2", 32'(bus.g_rptr_sync), 32'b001);
        chk("st_brptr2", 32'(bus.b_rptr_sync), 32'd0);
        tick(1);
        chk("st_brptr3", 32'(bus.b_rptr_sync), 32'd1);
        chk("st_used3",  32'(bus.wr_used), 32'd3);
        tick(1);
        chk_level("st4", 3'd2, 3'd2, 1'b0);

        // Full: wrap bit differs, low bits equal
        bus.b_wptr = 3'b100;
        bus.g_rptr = 3'b000;
        tick(4);
        chk_level("full", 3'd4, 3'd0, 1'b1);

        // Walk the read pointer forward to empty, then across the wrap
        set_rptr(3'b001);
        set_rptr(3'b011);
        set_rptr(3'b010);
        chk_level("walk3", 3'd1, 3'd3, 1'b0);
        set_rptr(3'b110);
        chk_level("empty", 3'd0, 3'd4, 1'b0);
        bus.b_wptr = 3'b111;
        tick(1);
        chk("w7_used", 32'(bus.wr_used), 32'd3);
        set_rptr(3'b111);
        chk("r5_used", 32'(bus.wr_used), 32'd2);
        set_rptr(3'b101);
        chk("r6_brptr", 32'(bus.b_rptr_sync), 32'd6);
        bus.b_wptr = 3'b001;
        tick(1);
        chk_level("wrap", 3'd3, 3'd1, 1'b1);
        chk("wrap_err", 32'(bus.gray_err), 32'd0);

        // Gray error: 000 -> 011 after valid
        set_rptr(3'b100);
        set_rptr(3'b000);
        bus.b_wptr = 3'b010;
        tick(1);
        chk("pre_err_used", 32'(bus.wr_used), 32'd2);
        chk("pre_err", 32'(bus.gray_err), 32'd0);
        bus.g_rptr = 3'b011;
        tick(3);
        chk("gerr_set", 32'(bus.gray_err), 32'(GC));
        tick(1);
        chk("gerr_used", 32'(bus.wr_used), 32'd0);
        set_rptr(3'b001);
        chk("gerr_hold", 32'(bus.gray_err), 32'(GC));
        chk("gerr_lvl", 32'(bus.wr_used), 32'd1);

        // Reset mid-operation
        bus.b_wptr = 3'b100;
        tick(1);
        chk("mid_used", 32'(bus.wr_used), 32'd3);
        #2;
        write_reset = 1'b0;
        #1;
        chk_level("mid_rst", 3'd0, 3'd4, 1'b0);
        chk("mid_valid", 32'(bus.sync_valid), 32'd0);
        chk("mid_err",   32'(bus.gray_err), 32'd0);
        chk("mid_gsync", 32'(bus.g_rptr_sync), 32'd0);
        chk("mid_brptr", 32'(bus.b_rptr_sync), 32'd0);
        @(negedge wclk);
        write_reset = 1'b1;
        tick(2);
        chk("re_gsync2", 32'(bus.g_rptr_sync), 32'b001);
        chk("re_valid2", 32'(bus.sync_valid), 32'd0);
        tick(1);
        chk("re_valid3", 32'(bus.sync_valid), 32'd0);
        tick(1);
        chk("re_valid4", 32'(bus.sync_valid), 32'd1);
        chk_level("re4", 3'd3, 3'd1, 1'b1);
        chk("re_err", 32'(bus.gray_err), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
